pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline interlock and wait-state controller for the five-stage pipelined CPU. It takes hazard information from the ID, EX and MEM stages and the ready handshake from the memory-mapped IO bus. It generates the PC/IR write enable, the ID/EX bubble and a global pipeline freeze, and it sequences multi-cycle IO accesses with a timeout. It sits beside the decode stage and replaces the purely combinational load-use stall with one owner for every stall source.

## Interface
- IO_TIMEOUT, default 255: maximum IO_WAIT cycles before the access is abandoned (range 1..65535).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ern  in  5  destination register of the EX instruction.
- ewreg  in  1  EX instruction writes the register file.
- em2reg  in  1  EX instruction is a load.
- m_io  in  1  MEM instruction is a load/store to the IO region.
- io_ready  in  1  IO bus completes the current access this cycle.
- io_req  out  1  IO access request, held until ready or timeout.
- wpcir  out  1  PC and IF/ID register write enable (1 = advance).
- bubble  out  1  load ID/EX with a NOP (clear wreg/wmem).
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers and PC/IR.
- io_err  out  1  sticky IO timeout flag.
- stall_cnt  out  16  saturating count of cycles with wpcir = 0.

## Operation
- States: RUN, IO_WAIT, ERR. Encoding is free. Reset state is RUN.
- The load-use hazard is luh = ewreg & em2reg & (ern != 0) & ((id_use_rs & ern == id_rs) | (id_use_rt & ern == id_rt)).
- RUN:
  - io_req = m_io.
  - If m_io & ~io_ready: freeze = 1 and next state is IO_WAIT; the wait counter loads 1.
  - If m_io & io_ready: no freeze; the access completes in a single cycle.
  - Otherwise, if luh: bubble = 1 and wpcir = 0.
- IO_WAIT:
  - io_req = 1.
  - freeze = ~io_ready.
  - On io_ready: next state is RUN.
  - Else if wait_cnt == IO_TIMEOUT: next state is ERR and io_err is set.
  - Else wait_cnt increments.
  - luh is ignored while frozen.
- ERR:
  - io_req = 0, freeze = 1, wpcir = 0, bubble = 0.
  - Held until reset. io_ready is ignored.
- Priority: freeze beats bubble. Whenever freeze = 1: wpcir = 0 and bubble = 0.
- wpcir = ~(freeze | bubble).
- stall_cnt increments every cycle wpcir = 0 and saturates at 16'hFFFF.
- An io_ready arriving in RUN without m_io is ignored.
- ern == 0 never causes a stall.

## Timing
- All outputs except io_err and stall_cnt are combinational from state and inputs; no added latency in RUN.
- Reset values: state RUN, wait_cnt 0, io_err 0, stall_cnt 0. With inputs idle, the outputs are io_req 0, wpcir 1, bubble 0, freeze 0.
- Load-use costs exactly one stall cycle. On the next edge the load has moved to MEM, so luh drops.
- IO access with ready after N wait cycles:
  - freeze is high for the RUN cycle plus N-1 IO_WAIT cycles.
  - The pipeline advances on the edge of the cycle where io_ready = 1.
- Timeout: with no io_ready, freeze is high for the RUN cycle plus IO_TIMEOUT IO_WAIT cycles. io_err rises at the edge closing the IO_TIMEOUT-th IO_WAIT cycle.
- io_ready and the timeout in the same cycle: ready wins and the next state is RUN.
- Reset asserted mid-IO_WAIT or in ERR: immediate return to reset values, without waiting for a clock edge.
- stall_cnt updates on the edge closing each stalled cycle.

## Test plan
- Load-use: ern = 5, ewreg = 1, em2reg = 1, id_rs = 5, id_use_rs = 1 for one cycle. Required: bubble = 1, wpcir = 0 for exactly one cycle; stall_cnt 0 -> 1. Repeat with ern = 0: no stall.
- Zero-wait IO: m_io = 1 with io_ready = 1 in the same cycle. Required: io_req = 1, freeze = 0, state stays RUN, stall_cnt unchanged.
- Three-cycle IO: m_io = 1, io_ready rises 3 cycles later. Required: freeze = 1 for 3 cycles and 0 in the ready cycle, io_req held, stall_cnt += 3.
- Timeout with IO_TIMEOUT = 4 and io_ready never asserted. Required: io_err = 1 after the 4th IO_WAIT cycle, io_req = 0, freeze stuck at 1. Then assert reset: all outputs return to reset values.
- Freeze priority: luh true while in IO_WAIT. Required: bubble = 0, freeze = 1. Also ready coincident with wait_cnt == IO_TIMEOUT: return to RUN, io_err = 0.
- Saturation: force 70000 stall cycles. Required: stall_cnt = 16'hFFFF and no wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock and IO wait-state controller: owns every stall source
// (load-use bubble, IO wait freeze, IO timeout lockup) and counts stall cycles.
module pipe_stall_ctrl #(
  parameter int IO_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        m_io,
  input  logic        io_ready,
  output logic        io_req,
  output logic        wpcir,
  output logic        bubble,
  output logic        freeze,
  output logic        io_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, IO_WAIT, ERR} state_t;

  localparam logic [15:0] TMO = 16'(IO_TIMEOUT);

  state_t      state, state_nx;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic        err_nx;
  logic        luh;

  assign luh = ewreg & em2reg & (ern != 5'd0) &
               ((id_use_rs & (ern == id_rs)) | (id_use_rt & (ern == id_rt)));

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    err_nx      = io_err;
    io_req      = 1'b0;
    freeze      = 1'b0;
    case (state)
      RUN: begin
        io_req = m_io;
        if (m_io && !io_ready) begin
          freeze      = 1'b1;
          state_nx    = IO_WAIT;
          wait_cnt_nx = 16'd1;
        end
      end
      IO_WAIT: begin
        io_req = 1'b1;
        freeze = ~io_ready;
        // ready wins over a coincident timeout
        if (io_ready) begin
          state_nx = RUN;
        end else if (wait_cnt == TMO) begin
          state_nx = ERR;
          err_nx   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
      ERR: freeze = 1'b1;
      default: state_nx = RUN;
    endcase
  end

  // a hazard still needs its bubble on the cycle the pipeline advances
  assign bubble = luh & ~freeze;
  assign wpcir  = ~(freeze | bubble);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 16'd0;
      io_err    <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      io_err   <= err_nx;
      if (!wpcir && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: driver predicts each cycle's outputs
// from a behavioural model into a queue; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ern = '0;
  logic        id_use_rs = 0, id_use_rt = 0, ewreg = 0, em2reg = 0, m_io = 0, io_ready = 0;
  logic        io_req, wpcir, bubble, freeze, io_err;
  logic [15:0] stall_cnt;

  pipe_stall_ctrl #(.IO_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ern(ern), .ewreg(ewreg),
    .em2reg(em2reg), .m_io(m_io), .io_ready(io_ready), .io_req(io_req),
    .wpcir(wpcir), .bubble(bubble), .freeze(freeze), .io_err(io_err),
    .stall_cnt(stall_cnt));

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs, rt, ern;
    logic use_rs, use_rt, ewreg, em2reg, m_io, io_ready;
  } stim_t;

  typedef struct {
    logic        io_req, wpcir, bubble, freeze, io_err;
    logic [15:0] stall_cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // model: 0 = running, 1 = waiting on IO, 2 = locked after timeout
  int m_mode = 0, m_waits = 0, m_stalls = 0;
  bit m_err = 0;

  function automatic exp_t predict(stim_t s, string tag);
    exp_t e;
    bit hazard, frz;
    hazard = s.ewreg && s.em2reg && s.ern != 0 &&
             ((s.use_rs && s.ern == s.rs) || (s.use_rt && s.ern == s.rt));
    case (m_mode)
      0:       begin e.io_req = s.m_io; frz = s.m_io && !s.io_ready; end
      1:       begin e.io_req = 1'b1;   frz = !s.io_ready; end
      default: begin e.io_req = 1'b0;   frz = 1'b1; end
    endcase
    e.freeze    = frz;
    e.bubble    = hazard && !frz;
    e.wpcir     = !(frz || e.bubble);
    e.io_err    = m_err;
    e.stall_cnt = 16'(m_stalls);
    e.tag       = tag;
    return e;
  endfunction

  function automatic void advance(stim_t s, exp_t e);
    if (!e.wpcir) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
    case (m_mode)
      0: if (s.m_io && !s.io_ready) begin m_mode = 1; m_waits = 1; end
      1: begin
        if (s.io_ready) m_mode = 0;
        else if (m_waits >= T) begin m_mode = 2; m_err = 1; end
        else m_waits++;
      end
      default: ;
    endcase
  endfunction

  // called at posedge+1; spans exactly one clock
  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    id_rs = s.rs; id_rt = s.rt; ern = s.ern; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    ewreg = s.ewreg; em2reg = s.em2reg; m_io = s.m_io; io_ready = s.io_ready;
    e = predict(s, tag);
    q.push_back(e);
    @(posedge clock);
    advance(s, e);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rs: 0, rt: 0, ern: 0, use_rs: 0, use_rt: 0, ewreg: 0, em2reg: 0, m_io: 0, io_ready: 0};
    return s;
  endfunction

  task automatic do_reset(input string tag);
    stim_t s;
    s = idle();
    id_rs = 0; id_rt = 0; ern = 0; id_use_rs = 0; id_use_rt = 0;
    ewreg = 0; em2reg = 0; m_io = 0; io_ready = 0;
    reset = 1'b1;
    m_mode = 0; m_waits = 0; m_stalls = 0; m_err = 0;
    q.push_back(predict(s, tag));
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  function automatic stim_t rand_stim(int io_pct, int rdy_pct);
    stim_t s;
    s.rs = 5'($urandom_range(0, 3));   s.rt = 5'($urandom_range(0, 3));
    s.ern = 5'($urandom_range(0, 3));
    s.use_rs = 1'($urandom); s.use_rt = 1'($urandom);
    s.ewreg = 1'($urandom);  s.em2reg = 1'($urandom);
    s.m_io = ($urandom_range(0, 99) < io_pct);
    s.io_ready = ($urandom_range(0, 99) < rdy_pct);
    return s;
  endfunction

  // monitor
  initial forever begin
    @(negedge clock);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({io_req, wpcir, bubble, freeze, io_err} !== {e.io_req, e.wpcir, e.bubble, e.freeze, e.io_err}
          || stall_cnt !== e.stall_cnt) begin
        errors++;
        $display("FAIL %s: got req=%b wpcir=%b bub=%b frz=%b err=%b cnt=%0d, want req=%b wpcir=%b bub=%b frz=%b err=%b cnt=%0d",
                 e.tag, io_req, wpcir, bubble, freeze, io_err, stall_cnt,
                 e.io_req, e.wpcir, e.bubble, e.freeze, e.io_err, e.stall_cnt);
      end
    end
  end

  initial begin
    stim_t s;
    @(posedge clock); #1;
    do_reset("reset");
    drive(idle(), "idle");

    // load-use, then the same with ern = 0
    s = idle(); s.ern = 5; s.ewreg = 1; s.em2reg = 1; s.rs = 5; s.use_rs = 1;
    drive(s, "luh");
    drive(idle(), "luh_after");
    s.ern = 0; s.rs = 0;
    drive(s, "luh_r0");
    drive(idle(), "luh_r0_after");

    // zero-wait IO
    s = idle(); s.m_io = 1; s.io_ready = 1;
    drive(s, "io_zero_wait");
    drive(idle(), "io_zero_after");

    // three-cycle IO with a load-use hazard present while frozen
    s = idle(); s.m_io = 1;
    drive(s, "io3_run");
    s.ern = 7; s.ewreg = 1; s.em2reg = 1; s.rt = 7; s.use_rt = 1;
    drive(s, "io3_wait1_luh");
    drive(s, "io3_wait2_luh");
    s.io_ready = 1;
    drive(s, "io3_ready_luh");
    drive(idle(), "io3_after");

    // ready coincident with wait count at the timeout
    s = idle(); s.m_io = 1;
    drive(s, "tmo_race_run");
    for (int i = 1; i < T; i++) drive(s, "tmo_race_wait");
    s.io_ready = 1;
    drive(s, "tmo_race_ready");
    drive(idle(), "tmo_race_after");

    // timeout into the sticky error state, then async reset mid-cycle
    s = idle(); s.m_io = 1;
    drive(s, "tmo_run");
    for (int i = 0; i < T; i++) drive(s, "tmo_wait");
    s.io_ready = 1;
    for (int i = 0; i < 3; i++) drive(s, "err_hold");
    do_reset("reset_from_err");
    drive(idle(), "post_err_idle");

    // async reset mid-wait
    s = idle(); s.m_io = 1;
    drive(s, "wait_run");
    drive(s, "wait_mid");
    do_reset("reset_from_wait");
    drive(idle(), "post_wait_idle");

    // randomized segments, each starting from reset
    for (int seg = 0; seg < 40; seg++) begin
      int io_pct, rdy_pct;
      io_pct  = $urandom_range(5, 40);
      rdy_pct = $urandom_range(10, 90);
      for (int i = 0; i < 50; i++) drive(rand_stim(io_pct, rdy_pct), "random");
      do_reset("random_reset");
    end

    // saturation: lock up in ERR and stall past 16'hFFFF
    s = idle(); s.m_io = 1;
    drive(s, "sat_run");
    for (int i = 0; i < T; i++) drive(s, "sat_wait");
    for (int i = 0; i < 66000; i++) drive(rand_stim(50, 50), "saturate");
    do_reset("sat_reset");
    drive(idle(), "sat_after");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
